mem_access_unit: RTL and testbench

// Memory-side stage between the datapath's MAR/MDR registers and word-addressed synchronous RAM.

---
 rtl/mem_access_unit_if.sv | 31 +++
 rtl/mem_access_unit.sv | 83 ++++++++
 tb/tb_mem_access_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bus bundle between the memory access unit, the control unit/datapath (MAR, MDR) and the RAM.
// The master side is the environment and the slave side is the access unit itself.
interface mem_access_unit_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              Read;
  logic              Write;
  logic [31:0]       MARQ;
  logic [DATA_W-1:0] MDRQ;
  logic [DATA_W-1:0] MdataIn;
  logic              MDRead;
  logic              Done;
  logic              Busy;
  logic              Fault;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output Read, Write, MARQ, MDRQ, mem_rdata,
    input  MdataIn, MDRead, Done, Busy, Fault, mem_addr, mem_wdata, mem_en, mem_we
  );

  modport slave (
    input  Read, Write, MARQ, MDRQ, mem_rdata,
    output MdataIn, MDRead, Done, Busy, Fault, mem_addr, mem_wdata, mem_en, mem_we
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-side stage: sequences one-word RAM reads/writes through fixed wait states
// and reports completion (Done/MDRead) or rejection (Fault) to the control unit.
module mem_access_unit #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 1
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);

  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_RD_DONE = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_WR_DONE = 3'd4;
  localparam logic [2:0] S_FLT     = 3'd5;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             addr_ok;

  assign addr_ok = ((bus.MARQ >> ADDR_W) == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bus.MdataIn   <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Read && bus.Write) begin
            state <= S_FLT;
          end else if (bus.Read || bus.Write) begin
            if (!addr_ok) begin
              state <= S_FLT;
            end else begin
              bus.mem_addr <= bus.MARQ[ADDR_W-1:0];
              cnt          <= '0;
              if (bus.Write) begin
                bus.mem_wdata <= bus.MDRQ;
                state         <= S_WR;
              end else begin
                state <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(READ_WAIT - 1)) begin
            bus.MdataIn <= bus.mem_rdata;
            state       <= S_RD_DONE;
          end
        end
        S_WR: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WRITE_WAIT - 1)) state <= S_WR_DONE;
        end
        S_RD_DONE, S_WR_DONE, S_FLT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state, so an async reset drops mem_en/mem_we without a clock edge.
  assign bus.Busy   = (state != S_IDLE);
  assign bus.Done   = (state == S_RD_DONE) || (state == S_WR_DONE) || (state == S_FLT);
  assign bus.MDRead = (state == S_RD_DONE);
  assign bus.Fault  = (state == S_FLT);
  assign bus.mem_en = (state == S_RD) || (state == S_WR);
  assign bus.mem_we = (state == S_WR);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table of single requests plus
// hand-written sequences for ignored mid-access requests and reset during an access.
module tb_mem_access_unit;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 32;
  localparam int READ_WAIT  = 2;
  localparam int WRITE_WAIT = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_access_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_WAIT(READ_WAIT), .WRITE_WAIT(WRITE_WAIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Synchronous RAM model with a preload port for the bench.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] rdata_q = '0;

  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    else if (bus.mem_en) rdata_q <= ram[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_q;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request and watch it to completion; lat=0 means Done never came.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [DATA_W-1:0] d, output int lat, output int en_c,
                        output int we_c, output logic flt, output logic mdr,
                        output logic busy_done, output logic busy_idle);
    lat = 0; en_c = 0; we_c = 0; flt = 1'b0; mdr = 1'b0; busy_done = 1'b0;
    @(negedge clk);
    bus.Read = rd; bus.Write = wr; bus.MARQ = a; bus.MDRQ = d;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.mem_en) en_c++;
      if (bus.mem_we) we_c++;
      if (bus.Done) begin
        lat = c; flt = bus.Fault; mdr = bus.MDRead; busy_done = bus.Busy;
        break;
      end
    end
    bus.Read = 1'b0; bus.Write = 1'b0;
    @(negedge clk);
    busy_idle = bus.Busy;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] marq;
    logic [31:0] mdrq;
    int          lat;
    int          en_c;
    int          we_c;
    logic        flt;
    logic        mdr;
    logic [31:0] mdata;
    logic [8:0]  addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int lat, en_c, we_c;
    logic flt, mdr, bd, bi;

    //         rd    wr    marq          mdrq          lat en we flt   mdr   mdata         addr     wdata
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0005, 32'hBAD0_BAD0, 3, 2, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, 9'h005, 32'h0000_0000};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_01FF, 32'h1234_5678, 2, 1, 1, 1'b0, 1'b0, 32'hDEAD_BEEF, 9'h1FF, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_01FF, 32'hBAD0_BAD0, 3, 2, 0, 1'b0, 1'b1, 32'h1234_5678, 9'h1FF, 32'h1234_5678};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0200, 32'hBAD0_BAD0, 1, 0, 0, 1'b1, 1'b0, 32'h1234_5678, 9'h1FF, 32'h1234_5678};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 1, 0, 0, 1'b1, 1'b0, 32'h1234_5678, 9'h1FF, 32'h1234_5678};
    vecs[5] = '{1'b0, 1'b1, 32'h8000_0003, 32'hFFFF_FFFF, 1, 0, 0, 1'b1, 1'b0, 32'h1234_5678, 9'h1FF, 32'h1234_5678};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0000, 32'hAAAA_5555, 2, 1, 1, 1'b0, 1'b0, 32'h1234_5678, 9'h000, 32'hAAAA_5555};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0000, 32'hBAD0_BAD0, 3, 2, 0, 1'b0, 1'b1, 32'hAAAA_5555, 9'h000, 32'hAAAA_5555};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0005, 32'hBAD0_BAD0, 3, 2, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, 9'h005, 32'hAAAA_5555};

    bus.Read = 1'b0; bus.Write = 1'b0; bus.MARQ = '0; bus.MDRQ = '0;
    ld_en = 1'b1; ld_addr = 9'h005; ld_data = 32'hDEAD_BEEF;

    // Power-on reset: all outputs quiet.
    @(negedge clk);
    @(negedge clk);
    ld_en = 1'b0;
    check("por outputs", {bus.mem_en, bus.mem_we, bus.Done, bus.Busy, bus.Fault, bus.MDRead}, 64'h0);
    check("por MdataIn", bus.MdataIn, 64'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle after release Busy", bus.Busy, 64'h0);
    check("idle after release mem_en", bus.mem_en, 64'h0);

    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].marq, vecs[i].mdrq, lat, en_c, we_c, flt, mdr, bd, bi);
      check($sformatf("v%0d latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d mem_en cycles", i), en_c, vecs[i].en_c);
      check($sformatf("v%0d mem_we cycles", i), we_c, vecs[i].we_c);
      check($sformatf("v%0d Fault", i), flt, vecs[i].flt);
      check($sformatf("v%0d MDRead", i), mdr, vecs[i].mdr);
      check($sformatf("v%0d Busy at Done", i), bd, 64'h1);
      check($sformatf("v%0d Busy in idle", i), bi, 64'h0);
      check($sformatf("v%0d MdataIn", i), bus.MdataIn, vecs[i].mdata);
      check($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].addr);
      check($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vecs[i].wdata);
    end

    // Write raised while a read is in flight is ignored.
    @(negedge clk);
    bus.Read = 1'b1; bus.MARQ = 32'h0; bus.MDRQ = 32'h0BAD_F00D;
    @(negedge clk);
    bus.Read = 1'b0; bus.Write = 1'b1;
    check("ign rd c1 mem_we", bus.mem_we, 64'h0);
    @(negedge clk);
    bus.Write = 1'b0;
    check("ign rd c2 en/we", {bus.mem_en, bus.mem_we}, 64'h2);
    @(negedge clk);
    check("ign rd c3 Done/MDRead/Fault", {bus.Done, bus.MDRead, bus.Fault}, 64'h6);
    check("ign rd MdataIn", bus.MdataIn, 64'hAAAA_5555);
    @(negedge clk);
    check("ign rd idle Busy", bus.Busy, 64'h0);
    check("ign rd mem_wdata", bus.mem_wdata, 64'hAAAA_5555);
    do_req(1'b1, 1'b0, 32'h0, 32'h0, lat, en_c, we_c, flt, mdr, bd, bi);
    check("ign rd ram[0] intact", bus.MdataIn, 64'hAAAA_5555);

    // Reset asserted during the first RD cycle abandons the access.
    @(negedge clk);
    bus.Read = 1'b1; bus.MARQ = 32'h5;
    @(posedge clk);
    #1;
    check("rst rd mem_en before", bus.mem_en, 64'h1);
    #2 reset = 1'b0;
    #1;
    check("rst rd mem_en dropped", bus.mem_en, 64'h0);
    check("rst rd MdataIn", bus.MdataIn, 64'h0);
    check("rst rd Busy", bus.Busy, 64'h0);
    bus.Read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    do_req(1'b1, 1'b0, 32'h5, 32'h0, lat, en_c, we_c, flt, mdr, bd, bi);
    check("post rst read latency", lat, READ_WAIT + 1);
    check("post rst read MdataIn", bus.MdataIn, 64'hDEAD_BEEF);

    // Reset mid-idle clears every registered output.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle rst MdataIn", bus.MdataIn, 64'h0);
    check("idle rst mem_addr", bus.mem_addr, 64'h0);
    check("idle rst mem_wdata", bus.mem_wdata, 64'h0);
    check("idle rst strobes", {bus.mem_en, bus.mem_we, bus.Done, bus.Busy, bus.Fault, bus.MDRead}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle rst release Busy/Done", {bus.Busy, bus.Done}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
